// File: rtl/scan_shift_engine.sv
// Synchronous scan register: captures chip observation nets, shifts them out serially
// at a programmable bit rate, and updates the chip control nets from the shift register.
module scan_shift_engine #(
   parameter int               WIDTH     = 32,
   parameter int               DIV       = 2,
   parameter logic [WIDTH-1:0] UPD_RESET = '0,
   localparam int              LW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LW-1:0]    cmd_len,
   input  logic             scan_in,
   output logic             scan_out,
   output logic             shift_tick,
   input  logic [WIDTH-1:0] chip_out,
   output logic [WIDTH-1:0] chip_in,
   output logic             busy,
   output logic             done
);

   localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_PRE  = DW'((DIV > 1) ? DIV - 2 : 0);
   localparam logic          TICK_ALL = (DIV == 1);

   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_CAP = 2'd1;
   localparam logic [1:0] OP_SHF = 2'd2;
   localparam logic [1:0] OP_UPD = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_CAP, S_UPD, S_SHF, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [DW-1:0]    div_cnt;
   logic [LW-1:0]    bit_cnt;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    len_sat;

   assign scan_out = sr[0];
   assign busy     = ~cmd_ready;

   always_comb begin
      len_sat = (cmd_len > LW'(WIDTH)) ? LW'(WIDTH) : cmd_len;
   end

   // shift_tick and done are registered one cycle ahead so they line up with
   // the cycle whose closing edge performs the shift / completes the command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         sr         <= '0;
         chip_in    <= UPD_RESET;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         len_q      <= '0;
         shift_tick <= 1'b0;
         done       <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         shift_tick <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  len_q     <= len_sat;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  case (cmd_op)
                     OP_CAP: state <= S_CAP;
                     OP_UPD: state <= S_UPD;
                     OP_SHF: begin
                        if (len_sat == '0) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end else begin
                           state      <= S_SHF;
                           shift_tick <= TICK_ALL;
                        end
                     end
                     OP_NOP: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                     default: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            S_CAP: begin
               sr    <= chip_out;
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_UPD: begin
               chip_in <= sr;
               state   <= S_DONE;
               done    <= 1'b1;
            end
            S_SHF: begin
               if (div_cnt == DIV_LAST) begin
                  sr      <= {scan_in, sr[WIDTH-1:1]};
                  div_cnt <= '0;
                  if (bit_cnt == len_q - LW'(1)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     bit_cnt    <= bit_cnt + LW'(1);
                     shift_tick <= TICK_ALL;
                  end
               end else begin
                  div_cnt    <= div_cnt + DW'(1);
                  shift_tick <= (div_cnt == DIV_PRE);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_shift_engine.sv
// Directed bench for scan_shift_engine: WIDTH=32, DIV=2, UPD_RESET=A5A50F0F.
module tb_scan_shift_engine;

   localparam int               WIDTH = 32;
   localparam int               DIV   = 2;
   localparam logic [WIDTH-1:0] URST  = 32'hA5A5_0F0F;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [5:0]       cmd_len;
   logic             scan_in;
   logic             scan_out;
   logic             shift_tick;
   logic [WIDTH-1:0] chip_out;
   logic [WIDTH-1:0] chip_in;
   logic             busy;
   logic             done;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   scan_shift_engine #(.WIDTH(WIDTH), .DIV(DIV), .UPD_RESET(URST)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .scan_in(scan_in), .scan_out(scan_out),
      .shift_tick(shift_tick), .chip_out(chip_out), .chip_in(chip_in),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for idle, presents one command for the accept edge, then
   // returns in the first cycle after that edge.
   task automatic issue(input logic [1:0] op, input logic [5:0] len);
      int w;
      w = 0;
      while (!cmd_ready && w < 200) begin
         step();
         w++;
      end
      tot_cnt++;
      if (w >= 200) $display("FAIL issue_wait: cmd_ready=%0b, required 1 within 200 cycles", cmd_ready);
      else pass_cnt++;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      step();
      cmd_valid = 1'b0;
   endtask

   // Runs an accepted SHIFT to completion, feeding din LSB-first and recording scan_out.
   task automatic run_shift(input logic [31:0] din, input logic [31:0] chip_ref,
                            output logic [31:0] dout, output int nticks, output int done_cyc,
                            output bit spacing_ok, output bit chip_stable);
      bit fin;
      dout = '0; nticks = 0; done_cyc = 0; spacing_ok = 1'b1; chip_stable = 1'b1; fin = 1'b0;
      for (int k = 1; k <= 100 && !fin; k++) begin
         if (chip_in !== chip_ref) chip_stable = 1'b0;
         if (shift_tick === 1'b1) begin
            if (k != DIV * (nticks + 1)) spacing_ok = 1'b0;
            if (nticks < 32) begin
               dout[nticks] = scan_out;
               scan_in      = din[nticks];
            end
            nticks++;
         end
         if (done === 1'b1) begin
            done_cyc = k;
            fin      = 1'b1;
         end
         step();
      end
      scan_in = 1'b0;
   endtask

   // Capture or update: one working cycle, then the done cycle.
   task automatic cap_or_upd(input logic [1:0] op);
      issue(op, 6'd0);
      step();
      step();
   endtask

   task automatic test_reset();
      tot_cnt++;
      if (chip_in !== URST) $display("FAIL reset_chip_in: got %h, required %h", chip_in, URST);
      else pass_cnt++;
      tot_cnt++;
      if (scan_out !== 1'b0) $display("FAIL reset_scan_out: got %b, required 0", scan_out);
      else pass_cnt++;
      tot_cnt++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready: ready=%b busy=%b, required 1/0", cmd_ready, busy);
      else pass_cnt++;
      tot_cnt++;
      if (done !== 1'b0 || shift_tick !== 1'b0) $display("FAIL reset_done: done=%b tick=%b, required 0/0", done, shift_tick);
      else pass_cnt++;
   endtask

   task automatic test_capture_shift();
      logic [31:0] d;
      int n, dc;
      bit sp, cs;
      chip_out = 32'hDEAD_BEEF;
      issue(2'd1, 6'd0);
      step();
      tot_cnt++;
      if (done !== 1'b1) $display("FAIL cap_done: done=%b two cycles after accept, required 1", done);
      else pass_cnt++;
      step();
      chip_out = 32'h0;
      issue(2'd2, 6'd32);
      run_shift(32'h0, URST, d, n, dc, sp, cs);
      tot_cnt++;
      if (d !== 32'hDEAD_BEEF) $display("FAIL cap_shift_data: got %h, required deadbeef", d);
      else pass_cnt++;
      tot_cnt++;
      if (n != 32) $display("FAIL cap_shift_ticks: got %0d, required 32", n);
      else pass_cnt++;
      tot_cnt++;
      if (!sp) $display("FAIL cap_shift_spacing: tick spacing wrong, required every 2 cycles");
      else pass_cnt++;
      tot_cnt++;
      if (dc != 65) $display("FAIL cap_shift_done: done at cycle %0d, required 65", dc);
      else pass_cnt++;
   endtask

   task automatic test_shift_update();
      logic [31:0] d;
      int n, dc;
      bit sp, cs;
      issue(2'd2, 6'd32);
      run_shift(32'h1234_5678, URST, d, n, dc, sp, cs);
      tot_cnt++;
      if (!cs) $display("FAIL shift_chip_stable: chip_in moved during shift, required %h", URST);
      else pass_cnt++;
      tot_cnt++;
      if (d !== 32'h0) $display("FAIL shift_out_zero: got %h, required 00000000", d);
      else pass_cnt++;
      issue(2'd3, 6'd0);
      tot_cnt++;
      if (chip_in !== URST) $display("FAIL upd_early: chip_in=%h one cycle after accept, required %h", chip_in, URST);
      else pass_cnt++;
      step();
      tot_cnt++;
      if (chip_in !== 32'h1234_5678) $display("FAIL upd_value: chip_in=%h, required 12345678", chip_in);
      else pass_cnt++;
      tot_cnt++;
      if (done !== 1'b1) $display("FAIL upd_done: done=%b, required 1", done);
      else pass_cnt++;
      step();
   endtask

   task automatic test_len_bounds();
      logic [31:0] d;
      int n, dc;
      bit sp, cs;
      chip_out = 32'h8000_0001;
      cap_or_upd(2'd1);
      issue(2'd2, 6'd0);
      tot_cnt++;
      if (done !== 1'b1 || shift_tick !== 1'b0) $display("FAIL len0_done: done=%b tick=%b, required 1/0", done, shift_tick);
      else pass_cnt++;
      step();
      cap_or_upd(2'd3);
      tot_cnt++;
      if (chip_in !== 32'h8000_0001) $display("FAIL len0_keep: chip_in=%h, required 80000001", chip_in);
      else pass_cnt++;
      issue(2'd2, 6'd63);
      run_shift(32'hFFFF_FFFF, 32'h8000_0001, d, n, dc, sp, cs);
      tot_cnt++;
      if (n != 32 || dc != 65) $display("FAIL len63_sat: ticks=%0d done_cyc=%0d, required 32/65", n, dc);
      else pass_cnt++;
      tot_cnt++;
      if (d !== 32'h8000_0001) $display("FAIL len63_out: got %h, required 80000001", d);
      else pass_cnt++;
      cap_or_upd(2'd3);
      tot_cnt++;
      if (chip_in !== 32'hFFFF_FFFF) $display("FAIL len63_upd: chip_in=%h, required ffffffff", chip_in);
      else pass_cnt++;
      chip_out = 32'hF0F0_F0F0;
      cap_or_upd(2'd1);
      issue(2'd2, 6'd4);
      run_shift(32'h0000_000F, 32'hFFFF_FFFF, d, n, dc, sp, cs);
      tot_cnt++;
      if (n != 4 || dc != 9) $display("FAIL len4_timing: ticks=%0d done_cyc=%0d, required 4/9", n, dc);
      else pass_cnt++;
      cap_or_upd(2'd3);
      tot_cnt++;
      if (chip_in !== 32'hFF0F_0F0F) $display("FAIL len4_partial: chip_in=%h, required ff0f0f0f", chip_in);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_shift();
      int n, w;
      bit seen;
      issue(2'd2, 6'd32);
      scan_in = 1'b1;
      n = 0;
      w = 0;
      while (n < 10 && w < 100) begin
         if (shift_tick === 1'b1) n++;
         step();
         w++;
      end
      tot_cnt++;
      if (n != 10) $display("FAIL mid_ticks: saw %0d ticks, required 10", n);
      else pass_cnt++;
      reset = 1'b1;
      step();
      reset   = 1'b0;
      scan_in = 1'b0;
      tot_cnt++;
      if (chip_in !== URST) $display("FAIL mid_chip_in: got %h, required %h", chip_in, URST);
      else pass_cnt++;
      tot_cnt++;
      if (cmd_ready !== 1'b1 || scan_out !== 1'b0 || done !== 1'b0) $display("FAIL mid_state: ready=%b scan_out=%b done=%b, required 1/0/0", cmd_ready, scan_out, done);
      else pass_cnt++;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (done !== 1'b0 || shift_tick !== 1'b0) seen = 1'b1;
         step();
      end
      tot_cnt++;
      if (seen) $display("FAIL mid_no_done: done or shift_tick pulsed after reset, required none");
      else pass_cnt++;
      cap_or_upd(2'd3);
      tot_cnt++;
      if (chip_in !== 32'h0) $display("FAIL mid_sr_zero: chip_in=%h after update, required 00000000", chip_in);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops  [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
      logic [5:0] lens [8] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0};
      int         lats [8] = '{0, 2, 2, 5, 1, 2, 0, 2};
      int idx, ndone, exp_c, lat_cur;
      bit outst, acc;
      idx = 0; ndone = 0; exp_c = 0; lat_cur = 0; outst = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = ops[0];
      cmd_len   = lens[0];
      for (int c = 0; c < 300 && !(idx == 8 && !outst); c++) begin
         acc = 1'b0;
         if (done === 1'b1) begin
            tot_cnt++;
            if (!outst || (lat_cur != 0 && c != exp_c) || (lat_cur == 0 && c > exp_c))
               $display("FAIL b2b_done: cmd %0d done at cycle %0d, required %0d (outstanding=%0b)", idx - 1, c, exp_c, outst);
            else pass_cnt++;
            outst = 1'b0;
            ndone++;
         end
         if (cmd_ready === 1'b1 && cmd_valid) begin
            tot_cnt++;
            if (outst) $display("FAIL b2b_ready: cmd_ready=1 at cycle %0d with command outstanding, required 0", c);
            else pass_cnt++;
            lat_cur = lats[idx];
            exp_c   = c + ((lat_cur == 0) ? 2 : lat_cur);
            outst   = 1'b1;
            acc     = 1'b1;
            idx++;
         end
         step();
         if (acc) begin
            if (idx < 8) begin
               cmd_op  = ops[idx];
               cmd_len = lens[idx];
            end else cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      tot_cnt++;
      if (idx != 8 || ndone != 8) $display("FAIL b2b_count: accepted=%0d done=%0d, required 8/8", idx, ndone);
      else pass_cnt++;
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_len   = 6'd0;
      scan_in   = 1'b0;
      chip_out  = '0;
      repeat (3) step();
      reset = 1'b0;
      test_reset();
      test_capture_shift();
      test_shift_update();
      test_len_bounds();
      test_reset_mid_shift();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
